// File: rtl/con_pkg.sv
// rtl/con_pkg.sv - controller button indices and the event record shared by the event queue.
package con_pkg;

  localparam int CON_NUM_BUTTONS = 16;
  localparam int CON_IW          = $clog2(CON_NUM_BUTTONS);

  // SNES controller bit positions within con_state
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef struct packed {
    logic              press;
    logic [CON_IW-1:0] idx;
  } con_evt_t;

endpackage

// File: rtl/con_event_queue_fifo.sv
// rtl/con_event_queue_fifo.sv - registered synchronous FIFO holding queued button events.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // a pop frees the slot the same-cycle push needs, so full+pop+push is legal
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/con_event_queue.sv
// rtl/con_event_queue.sv - debounces controller state and queues press/release events for the CPU.
module con_event_queue
  import con_pkg::*;
#(
  parameter int NUM_BUTTONS     = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BUTTONS-1:0]        con_state,
  output logic [NUM_BUTTONS-1:0]        btn_state,
  output logic                          evt_valid,
  output logic [$clog2(NUM_BUTTONS):0]  evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          irq
);

  localparam int IW = $clog2(NUM_BUTTONS);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_BUTTONS-1:0] candidate;
  logic [NUM_BUTTONS-1:0] reported;
  logic [NUM_BUTTONS-1:0] diff;
  logic [DW-1:0]          db_cnt;
  logic [IW-1:0]          sel;
  logic [IW:0]            push_data;
  logic                   pending;
  logic                   can_push;
  logic                   do_push;
  logic                   fifo_full;
  logic                   fifo_empty;

  // whole-vector debounce: any change anywhere restarts the stability window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      candidate <= '0;
      db_cnt    <= '0;
      btn_state <= '0;
    end else if (con_state != candidate) begin
      candidate <= con_state;
      db_cnt    <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_state <= candidate;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign diff = btn_state ^ reported;

  always_comb begin
    sel = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (diff[i]) begin
        sel = IW'(i);
      end
    end
  end

  assign pending   = |diff;
  assign can_push  = !fifo_full || (evt_ready && !fifo_empty);
  assign do_push   = pending && can_push;
  assign push_data = {btn_state[sel], sel};

  // reported only advances on a successful push, so a blocked event is retried, not lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reported <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        reported[sel] <= btn_state[sel];
      end
      if (pending && !can_push) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (IW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .push_data (push_data),
    .pop       (evt_ready),
    .head_data (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (evt_count)
  );

  assign evt_valid = !fifo_empty;
  assign irq       = !fifo_empty;

endmodule

// File: tb/tb_con_event_queue.sv
// tb/tb_con_event_queue.sv - scoreboard bench for con_event_queue against a run-length reference model.
module tb_con_event_queue;
  import con_pkg::*;

  localparam int NB    = 16;
  localparam int DEPTH = 4;
  localparam int DEB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] con_state;
  logic [15:0] btn_state;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic        evt_ready;
  logic [2:0]  evt_count;
  logic        overflow;
  logic        clr_overflow;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  con_evt_t    sb_q[$];
  logic [15:0] m_last = '0;
  logic [15:0] m_btn  = '0;
  logic [15:0] m_rep  = '0;
  int          m_run  = 1;
  int          m_cnt  = 0;
  logic        m_ovf  = 1'b0;

  always #5 clk = ~clk;

  con_event_queue #(
    .NUM_BUTTONS     (NB),
    .FIFO_DEPTH      (DEPTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .con_state    (con_state),
    .btn_state    (btn_state),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .irq          (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a value is accepted once it has been sampled DEB+1 times in a row
  task automatic model_step();
    logic [15:0] diff;
    logic        pop;
    logic        canp;
    int          idx;
    con_evt_t    e;
    if (!rst_n) begin
      m_last = '0; m_run = 1; m_btn = '0; m_rep = '0;
      m_cnt  = 0;  m_ovf = 1'b0;
      sb_q.delete();
      return;
    end
    pop  = evt_ready && (m_cnt > 0);
    diff = m_btn ^ m_rep;
    canp = 1'b1;
    if (diff != 0) begin
      idx = 0;
      while (!diff[idx]) idx++;
      canp = (m_cnt < DEPTH) || pop;
      if (canp) begin
        e.press = m_btn[idx];
        e.idx   = CON_IW'(idx);
        sb_q.push_back(e);
        m_rep[idx] = m_btn[idx];
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (canp && clr_overflow) m_ovf = 1'b0;
    if (pop) m_cnt--;
    if (con_state == m_last) begin
      if (m_run < DEB + 1) m_run++;
    end else begin
      m_last = con_state;
      m_run  = 1;
    end
    if (m_run >= DEB + 1) m_btn = m_last;
  endtask

  always @(posedge clk) begin
    #1;
    model_step();
  end

  // monitor: compares visible state and pops the scoreboard on every handshake
  always @(negedge clk) begin
    con_evt_t e;
    chk("btn_state", btn_state, m_btn);
    chk("evt_count", evt_count, m_cnt);
    chk("overflow",  overflow,  m_ovf);
    chk("evt_valid", evt_valid, m_cnt != 0);
    chk("irq",       irq,       m_cnt != 0);
    if (rst_n && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("evt_data", evt_data, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int hold;
    rst_n = 1'b0; con_state = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    step(2);
    chk("rst_evt_data", evt_data, 5'd0);
    rst_n = 1'b1;

    // single press: accepted on the fifth edge, event visible one edge later
    con_state = 16'h0001;
    step(4);
    chk("p1_btn_early", btn_state, 16'h0000);
    step(1);
    chk("p1_btn", btn_state, 16'h0001);
    chk("p1_valid_early", evt_valid, 1'b0);
    step(1);
    chk("p1_valid", evt_valid, 1'b1);
    chk("p1_data", evt_data, {1'b1, 4'd0});
    evt_ready = 1'b1; step(2); evt_ready = 1'b0;

    // release, then a 3-cycle glitch that must be swallowed
    con_state = 16'h0000; step(8);
    evt_ready = 1'b1; step(3);
    con_state = 16'h0001; step(3);
    con_state = 16'h0000; step(8);
    chk("p2_count", evt_count, 3'd0);

    // simultaneous presses emerge in ascending index order
    evt_ready = 1'b0; con_state = 16'h0910; step(10);
    chk("p3_count", evt_count, 3'd3);
    evt_ready = 1'b1; step(5);
    con_state = 16'h0000; step(12);

    // twelve presses against a four-entry queue
    evt_ready = 1'b0; con_state = 16'h0FFF; step(20);
    chk("p4_overflow", overflow, 1'b1);
    chk("p4_count", evt_count, 3'd4);
    evt_ready = 1'b1; step(12);
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    chk("p4_clr", overflow, 1'b0);

    // full queue with a simultaneous pop and push
    evt_ready = 1'b0; con_state = 16'h0000; step(10);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("p5_count", evt_count, 3'd4);
    step(2);
    evt_ready = 1'b1; step(15);
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;

    // reset with events queued
    evt_ready = 1'b0; con_state = 16'h0007; step(10);
    chk("p6_count", evt_count, 3'd3);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("p6_valid", evt_valid, 1'b0);
    chk("p6_cnt0", evt_count, 3'd0);
    chk("p6_btn", btn_state, 16'h0000);
    chk("p6_data", evt_data, 5'd0);
    step(10);
    evt_ready = 1'b1; step(6);

    // randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: con_state = 16'($urandom) & 16'h0FFF;
          1: con_state = con_state ^ (16'h0001 << $urandom_range(0, 11));
          2: con_state = 16'h0000;
          default: con_state = con_state;
        endcase
        hold = $urandom_range(1, 10);
      end
      hold--;
      evt_ready    = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      rst_n        = ($urandom_range(0, 799) != 0);
      step(1);
    end

    rst_n = 1'b1; clr_overflow = 1'b0; evt_ready = 1'b1;
    step(40);
    chk("final_drained", evt_count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
